// File: rtl/cv32e40p_wb_pkg.sv
//------------------------------------------------------------------------------
// Module : cv32e40p_wb_pkg
// Brief  : Shared types for the write-back arbiter and its APU result buffer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cv32e40p_wb_pkg;

  // Storage widths of a buffered result; the arbiter's ADDR_WIDTH/DATA_WIDTH must not exceed them.
  localparam int WB_ADDR_WIDTH = 6;
  localparam int WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] waddr;
    logic [WB_DATA_WIDTH-1:0] wdata;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_EX   = 2'd1,
    WB_LSU  = 2'd2,
    WB_APU  = 2'd3
  } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/cv32e40p_wb_fifo.sv
//------------------------------------------------------------------------------
// Module : cv32e40p_wb_fifo
// Brief  : Small synchronous FIFO of write-back requests with occupancy count.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cv32e40p_wb_fifo
  import cv32e40p_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_req_t       push_data,
  input  logic          pop,
  output wb_req_t       head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t         r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cv32e40p_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module : cv32e40p_wb_arbiter
// Brief  : Merges EX, LSU and APU results onto two RF write ports; tracks pending APU destinations.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cv32e40p_wb_arbiter
  import cv32e40p_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ex_we_i,
  input  logic [ADDR_WIDTH-1:0]       ex_waddr_i,
  input  logic [DATA_WIDTH-1:0]       ex_wdata_i,
  input  logic                        lsu_we_i,
  input  logic [ADDR_WIDTH-1:0]       lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]       lsu_wdata_i,
  input  logic                        apu_valid_i,
  input  logic [ADDR_WIDTH-1:0]       apu_waddr_i,
  input  logic [DATA_WIDTH-1:0]       apu_wdata_i,
  output logic                        apu_ready_o,
  input  logic                        apu_issue_i,
  input  logic [ADDR_WIDTH-1:0]       apu_issue_waddr_i,
  output logic [2**ADDR_WIDTH-1:0]    pending_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        rf_we_a_o,
  output logic [ADDR_WIDTH-1:0]       rf_waddr_a_o,
  output logic [DATA_WIDTH-1:0]       rf_wdata_a_o,
  output logic                        rf_we_b_o,
  output logic [ADDR_WIDTH-1:0]       rf_waddr_b_o,
  output logic [DATA_WIDTH-1:0]       rf_wdata_b_o
);

  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int NREG = 2**ADDR_WIDTH;

  wb_req_t               w_head;
  wb_req_t               w_push_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_apu_avail;
  logic                  w_apu_grant;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_apu_addr;
  logic [DATA_WIDTH-1:0] w_apu_data;
  wb_src_e               w_src_a;
  wb_src_e               w_src_b;
  logic [NREG-1:0]       r_pending;
  logic [NREG-1:0]       w_set_mask;
  logic [NREG-1:0]       w_clr_mask;

  assign apu_ready_o = ~rst & ~w_full;
  assign w_accept    = apu_valid_i & apu_ready_o;

  // Buffered results always go before a live one, so bypass is only possible when the FIFO is empty.
  assign w_apu_avail = ~rst & (~w_empty | w_accept);
  assign w_apu_addr  = w_empty ? apu_waddr_i : ADDR_WIDTH'(w_head.waddr);
  assign w_apu_data  = w_empty ? apu_wdata_i : DATA_WIDTH'(w_head.wdata);

  always_comb begin
    w_src_a = WB_NONE;
    w_src_b = WB_NONE;
    if (!rst) begin
      if (ex_we_i)          w_src_a = WB_EX;
      else if (w_apu_avail) w_src_a = WB_APU;
      if (lsu_we_i)                               w_src_b = WB_LSU;
      else if (w_apu_avail && w_src_a != WB_APU)  w_src_b = WB_APU;
    end
  end

  assign w_apu_grant = (w_src_a == WB_APU) | (w_src_b == WB_APU);
  assign w_pop       = w_apu_grant & ~w_empty;
  assign w_push      = w_accept & ~(w_apu_grant & w_empty);
  assign w_push_data = '{waddr: WB_ADDR_WIDTH'(apu_waddr_i), wdata: WB_DATA_WIDTH'(apu_wdata_i)};

  cv32e40p_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count_o)
  );

  always_comb begin
    rf_we_a_o    = 1'b0;
    rf_waddr_a_o = '0;
    rf_wdata_a_o = '0;
    case (w_src_a)
      WB_EX:   begin rf_we_a_o = 1'b1; rf_waddr_a_o = ex_waddr_i; rf_wdata_a_o = ex_wdata_i; end
      WB_APU:  begin rf_we_a_o = 1'b1; rf_waddr_a_o = w_apu_addr; rf_wdata_a_o = w_apu_data; end
      default: ;
    endcase
  end

  always_comb begin
    rf_we_b_o    = 1'b0;
    rf_waddr_b_o = '0;
    rf_wdata_b_o = '0;
    case (w_src_b)
      WB_LSU:  begin rf_we_b_o = 1'b1; rf_waddr_b_o = lsu_waddr_i; rf_wdata_b_o = lsu_wdata_i; end
      WB_APU:  begin rf_we_b_o = 1'b1; rf_waddr_b_o = w_apu_addr;  rf_wdata_b_o = w_apu_data;  end
      default: ;
    endcase
  end

  // A re-issue to a register retiring this cycle must survive, so set is applied after clear.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (apu_issue_i && apu_issue_waddr_i != '0) w_set_mask[apu_issue_waddr_i] = 1'b1;
    if (w_apu_grant)                            w_clr_mask[w_apu_addr]        = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end

  assign pending_o = r_pending;

  a_ex_lsu_conflict: assert property (@(posedge clk) disable iff (rst)
    !(ex_we_i && lsu_we_i && ex_waddr_i == lsu_waddr_i && ex_waddr_i != '0));
  a_issue_pending: assert property (@(posedge clk) disable iff (rst)
    !(apu_issue_i && r_pending[apu_issue_waddr_i] && !w_clr_mask[apu_issue_waddr_i]));
  a_result_unexpected: assert property (@(posedge clk) disable iff (rst)
    !(apu_valid_i && !r_pending[apu_waddr_i]));

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_cv32e40p_wb_arbiter
// Brief  : Self-checking bench for cv32e40p_wb_arbiter against a queue-based reference model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cv32e40p_wb_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NREG  = 2**AW;

  logic clk = 1'b0;
  logic rst;
  logic ex_we, lsu_we, apu_valid, apu_issue;
  logic [AW-1:0] ex_waddr, lsu_waddr, apu_waddr, apu_issue_waddr;
  logic [DW-1:0] ex_wdata, lsu_wdata, apu_wdata;
  logic apu_ready, rf_we_a, rf_we_b;
  logic [NREG-1:0] pending;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] rf_waddr_a, rf_waddr_b;
  logic [DW-1:0] rf_wdata_a, rf_wdata_b;

  always #5 clk = ~clk;

  cv32e40p_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .apu_valid_i(apu_valid), .apu_waddr_i(apu_waddr), .apu_wdata_i(apu_wdata),
    .apu_ready_o(apu_ready),
    .apu_issue_i(apu_issue), .apu_issue_waddr_i(apu_issue_waddr),
    .pending_o(pending), .fifo_count_o(fifo_count),
    .rf_we_a_o(rf_we_a), .rf_waddr_a_o(rf_waddr_a), .rf_wdata_a_o(rf_wdata_a),
    .rf_we_b_o(rf_we_b), .rf_waddr_b_o(rf_waddr_b), .rf_wdata_b_o(rf_wdata_b)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } res_t;

  // Reference state: accepted APU results in acceptance order, and the register scoreboard.
  res_t           mq[$];
  bit [NREG-1:0]  m_pend;
  logic [AW-1:0]  inflight[$];
  bit             hold;

  bit            e_ready, e_we_a, e_we_b;
  logic [AW-1:0] e_addr_a, e_addr_b;
  logic [DW-1:0] e_data_a, e_data_b;
  bit            m_accept, m_retire, m_from_q;
  res_t          m_ret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_eval();
    bit   have, on_a, on_b;
    res_t cand;
    have     = 1'b0;
    cand     = '0;
    m_from_q = 1'b0;
    e_ready  = !rst && (mq.size() < DEPTH);
    m_accept = apu_valid && e_ready;
    if (!rst) begin
      if (mq.size() > 0) begin
        cand = mq[0]; have = 1'b1; m_from_q = 1'b1;
      end else if (m_accept) begin
        cand.a = apu_waddr; cand.d = apu_wdata; have = 1'b1;
      end
    end
    on_a     = !rst && !ex_we && have;
    on_b     = !rst && ex_we && !lsu_we && have;
    m_retire = on_a || on_b;
    m_ret    = cand;
    e_we_a   = !rst && (ex_we || have);
    e_addr_a = rst ? '0 : ex_we ? ex_waddr : on_a ? cand.a : '0;
    e_data_a = rst ? '0 : ex_we ? ex_wdata : on_a ? cand.d : '0;
    e_we_b   = !rst && (lsu_we || on_b);
    e_addr_b = rst ? '0 : lsu_we ? lsu_waddr : on_b ? cand.a : '0;
    e_data_b = rst ? '0 : lsu_we ? lsu_wdata : on_b ? cand.d : '0;
  endtask

  task automatic model_commit();
    res_t r;
    if (rst) begin
      mq.delete();
      m_pend = '0;
      inflight.delete();
      hold = 1'b0;
      return;
    end
    if (m_retire) begin
      if (m_from_q) void'(mq.pop_front());
      m_pend[m_ret.a] = 1'b0;
    end
    if (m_accept && !(m_retire && !m_from_q)) begin
      r.a = apu_waddr; r.d = apu_wdata;
      mq.push_back(r);
    end
    if (apu_issue && apu_issue_waddr != '0) m_pend[apu_issue_waddr] = 1'b1;
    if (m_accept && inflight.size() > 0 && inflight[0] == apu_waddr) void'(inflight.pop_front());
    if (apu_issue) inflight.push_back(apu_issue_waddr);
    hold = apu_valid && !m_accept;
  endtask

  // Called at negedge with inputs driven; compares every output against the model.
  task automatic settle();
    #1;
    model_eval();
    chk("apu_ready", 64'(apu_ready), 64'(e_ready));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("rf_we_a", 64'(rf_we_a), 64'(e_we_a));
    chk("rf_waddr_a", 64'(rf_waddr_a), 64'(e_addr_a));
    chk("rf_wdata_a", 64'(rf_wdata_a), 64'(e_data_a));
    chk("rf_we_b", 64'(rf_we_b), 64'(e_we_b));
    chk("rf_waddr_b", 64'(rf_waddr_b), 64'(e_addr_b));
    chk("rf_wdata_b", 64'(rf_wdata_b), 64'(e_data_b));
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; ex_we = 1'b0; lsu_we = 1'b0; apu_valid = 1'b0; apu_issue = 1'b0;
    ex_waddr = '0; lsu_waddr = '0; apu_waddr = '0; apu_issue_waddr = '0;
    ex_wdata = '0; lsu_wdata = '0; apu_wdata = '0;
  endtask

  task automatic do_issue(input logic [AW-1:0] a);
    idle(); apu_issue = 1'b1; apu_issue_waddr = a; settle(); tick();
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      ex_we     = $urandom_range(0, 1) == 1;
      ex_waddr  = AW'($urandom);
      ex_wdata  = $urandom;
      lsu_we    = $urandom_range(0, 1) == 1;
      lsu_waddr = AW'($urandom);
      lsu_wdata = $urandom;
      if (ex_we && lsu_we && ex_waddr == lsu_waddr && ex_waddr != '0) lsu_waddr = ex_waddr ^ AW'(1);
      if (!hold) begin
        if (inflight.size() > 0 && $urandom_range(0, 9) < 6) begin
          apu_valid = 1'b1; apu_waddr = inflight[0]; apu_wdata = $urandom;
        end else begin
          apu_valid = 1'b0; apu_waddr = '0; apu_wdata = '0;
        end
      end
      apu_issue = 1'b0;
      apu_issue_waddr = '0;
      if ($urandom_range(0, 9) < 4) begin
        for (int k = 0; k < 4; k++) begin
          logic [AW-1:0] a;
          a = AW'($urandom_range(1, NREG - 1));
          if (!apu_issue && !m_pend[a]) begin apu_issue = 1'b1; apu_issue_waddr = a; end
        end
      end
      settle();
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    hold = 1'b0;
    m_pend = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // Held in reset: no writes, not ready, empty state.
    settle();
    chk("lit_reset_we_a", 64'(rf_we_a), 64'd0);
    chk("lit_reset_ready", 64'(apu_ready), 64'd0);
    chk("lit_reset_count", 64'(fifo_count), 64'd0);
    tick();

    // Bypass with empty FIFO.
    do_issue(6'h23);
    idle(); apu_valid = 1'b1; apu_waddr = 6'h23; apu_wdata = 32'hDEADBEEF;
    settle();
    chk("lit_bypass_we_a", 64'(rf_we_a), 64'd1);
    chk("lit_bypass_addr", 64'(rf_waddr_a), 64'h23);
    chk("lit_bypass_data", 64'(rf_wdata_a), 64'hDEADBEEF);
    chk("lit_bypass_count", 64'(fifo_count), 64'd0);
    tick();
    idle(); settle();
    chk("lit_bypass_clear", 64'(pending[6'h23]), 64'd0);
    tick();

    // Buffering while both ports are busy, then in-order drain on port A.
    do_issue(6'h21);
    do_issue(6'h22);
    for (int c = 0; c < 3; c++) begin
      idle();
      ex_we = 1'b1; ex_waddr = 6'd5; ex_wdata = 32'h5555_0000 + c;
      lsu_we = 1'b1; lsu_waddr = 6'd6; lsu_wdata = 32'h6666_0000 + c;
      if (c < 2) begin apu_valid = 1'b1; apu_waddr = 6'h21 + AW'(c); apu_wdata = 32'hA000_0000 + c; end
      settle();
      if (c == 2) begin
        chk("lit_buf_count2", 64'(fifo_count), 64'd2);
        chk("lit_buf_ready0", 64'(apu_ready), 64'd0);
      end
      tick();
    end
    idle(); settle();
    chk("lit_drain1_addr", 64'(rf_waddr_a), 64'h21);
    chk("lit_drain1_we_b", 64'(rf_we_b), 64'd0);
    tick();
    idle(); settle();
    chk("lit_drain2_addr", 64'(rf_waddr_a), 64'h22);
    chk("lit_drain2_count", 64'(fifo_count), 64'd1);
    tick();
    idle(); settle();
    chk("lit_drain_empty", 64'(fifo_count), 64'd0);
    tick();

    // Full FIFO backpressure with a held APU result.
    do_issue(6'h24); do_issue(6'h25); do_issue(6'h26);
    for (int c = 0; c < 2; c++) begin
      idle(); ex_we = 1'b1; ex_waddr = 6'd5; lsu_we = 1'b1; lsu_waddr = 6'd6;
      apu_valid = 1'b1; apu_waddr = 6'h24 + AW'(c); apu_wdata = 32'hB000_0000 + c;
      settle(); tick();
    end
    idle(); lsu_we = 1'b1; lsu_waddr = 6'd6; apu_valid = 1'b1; apu_waddr = 6'h26; apu_wdata = 32'hB000_0002;
    settle();
    chk("lit_bp_ready0", 64'(apu_ready), 64'd0);
    chk("lit_bp_head", 64'(rf_waddr_a), 64'h24);
    tick();
    settle();
    chk("lit_bp_ready1", 64'(apu_ready), 64'd1);
    chk("lit_bp_next", 64'(rf_waddr_a), 64'h25);
    tick();
    idle(); settle();
    chk("lit_bp_last", 64'(rf_wdata_a), 64'hB000_0002);
    tick();

    // Scoreboard set, and same-cycle retire plus re-issue.
    do_issue(6'h2A);
    idle(); apu_valid = 1'b1; apu_waddr = 6'h2A; apu_wdata = 32'h1; apu_issue = 1'b1; apu_issue_waddr = 6'h2A;
    settle();
    chk("lit_sb_set", 64'(pending[42]), 64'd1);
    tick();
    idle(); settle();
    chk("lit_sb_setwins", 64'(pending[42]), 64'd1);
    tick();
    idle(); apu_valid = 1'b1; apu_waddr = 6'h2A; apu_wdata = 32'h2;
    settle(); tick();
    idle(); settle();
    chk("lit_sb_clear", 64'(pending[42]), 64'd0);
    tick();

    // Reset with buffered results and pending bits.
    do_issue(6'h31); do_issue(6'h32); do_issue(6'h33);
    for (int c = 0; c < 2; c++) begin
      idle(); ex_we = 1'b1; ex_waddr = 6'd5; lsu_we = 1'b1; lsu_waddr = 6'd6;
      apu_valid = 1'b1; apu_waddr = 6'h31 + AW'(c); apu_wdata = 32'hC000_0000 + c;
      settle(); tick();
    end
    idle(); rst = 1'b1; ex_we = 1'b1; ex_waddr = 6'd5;
    settle();
    chk("lit_rst_we_a", 64'(rf_we_a), 64'd0);
    chk("lit_rst_we_b", 64'(rf_we_b), 64'd0);
    tick();
    idle(); settle();
    chk("lit_rst_count", 64'(fifo_count), 64'd0);
    chk("lit_rst_pending", 64'(pending), 64'd0);
    tick();
    do_issue(6'h34);
    idle(); apu_valid = 1'b1; apu_waddr = 6'h34; apu_wdata = 32'h3434;
    settle();
    chk("lit_rst_bypass", 64'(rf_waddr_a), 64'h34);
    tick();

    // Port B fallback while EX holds port A.
    do_issue(6'h35);
    idle(); ex_we = 1'b1; ex_waddr = 6'd7; ex_wdata = 32'h7; apu_valid = 1'b1; apu_waddr = 6'h35; apu_wdata = 32'h3535;
    settle();
    chk("lit_portb_we", 64'(rf_we_b), 64'd1);
    chk("lit_portb_addr", 64'(rf_waddr_b), 64'h35);
    tick();

    // Randomized traffic from a clean state.
    idle(); rst = 1'b1; settle(); tick();
    random_phase(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cv32e40p_wb_arbiter.md
Name: cv32e40p_wb_arbiter

Overview:
- Write-back stage directly upstream of the latch-based register file.
- Merges three result producers onto the register file's two write ports (A and B):
  - EX/ALU: single-cycle, never stalls.
  - LSU: load data, never stalls.
  - APU/FPU: variable latency, valid/ready handshake.
- APU results that cannot get a free port are buffered in a small FIFO.
- A pending-destination scoreboard lets the decoder stall on RAW/WAW hazards against outstanding APU results.

Parameters:
- ADDR_WIDTH, 6, register address width; bit 5 selects the FP bank.
- DATA_WIDTH, 32, result width.
- FIFO_DEPTH, 2, APU result buffer entries; must be ≥1 and a power of two.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock, synchronous and active-high
- ex_we_i  in  1  EX result valid
- ex_waddr_i  in  ADDR_WIDTH  EX destination
- ex_wdata_i  in  DATA_WIDTH  EX result
- lsu_we_i  in  1  load result valid
- lsu_waddr_i  in  ADDR_WIDTH  load destination
- lsu_wdata_i  in  DATA_WIDTH  load data
- apu_valid_i  in  1  APU result valid
- apu_waddr_i  in  ADDR_WIDTH  APU destination
- apu_wdata_i  in  DATA_WIDTH  APU result
- apu_ready_o  out  1  APU result accepted when valid & ready
- apu_issue_i  in  1  APU op issued this cycle
- apu_issue_waddr_i  in  ADDR_WIDTH  destination of issued APU op
- pending_o  out  2**ADDR_WIDTH  scoreboard, one bit per register
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  buffered APU results
- rf_we_a_o / rf_waddr_a_o / rf_wdata_a_o  out  1/ADDR_WIDTH/DATA_WIDTH  RF port A
- rf_we_b_o / rf_waddr_b_o / rf_wdata_b_o  out  1/ADDR_WIDTH/DATA_WIDTH  RF port B

Behaviour:
- **Reset:** FIFO empty, fifo_count_o=0, pending_o=0.
  - While rst=1: apu_ready_o=0 and rf_we_a_o=rf_we_b_o=0; nothing is written or enqueued.
  - Reset mid-operation discards FIFO contents and clears all pending bits on the next edge.
- **Write ports:** combinational from inputs and FIFO head (zero added latency). When rf_we_x_o=0, the matching addr/data outputs are driven 0.
- **Port A grant priority:** ex_we_i, then FIFO head, then APU bypass.
- **Port B grant priority:** lsu_we_i, then FIFO head (if not granted on A), then APU bypass (if not granted on A).
- **One APU retire per cycle:** at most one APU-sourced write per cycle, either FIFO head or bypass, never both.
- **Bypass:** allowed only when the FIFO is empty; apu_valid_i data goes straight to a free port without being enqueued.
- **apu_ready_o = (fifo_count < FIFO_DEPTH)**; it does not depend on port availability.
  - Accepted, FIFO empty, port free: bypass.
  - Accepted otherwise: enqueue at the tail.
- **Simultaneous dequeue and enqueue:** count unchanged. When full, the head may drain, but ready is already low that cycle, so there is no same-cycle refill.
- **Ordering:** APU results retire strictly in acceptance order.
- **Scoreboard:**
  - Set: apu_issue_i sets pending[apu_issue_waddr_i].
  - Clear: the bit clears on the cycle its APU result is granted a port.
  - Same address set and clear in one cycle: set wins.
  - Address 0 is never set.
- **Illegal, assertion-checked, undefined result:**
  - ex and lsu writing the same nonzero address in the same cycle.
  - Issue to an already-pending address.
  - apu_valid_i while the scoreboard shows no pending destination for apu_waddr_i.
- **Writes to address 0:** passed through; the RF discards them.
- **Widths:** no arithmetic beyond the FIFO pointers, which wrap modulo FIFO_DEPTH. Count is one bit wider than the pointers.

Decomposition:
- Package cv32e40p_wb_pkg:
  - wb_req_t struct {waddr, wdata}.
  - Source-select enum {WB_NONE, WB_EX, WB_LSU, WB_APU}.
- Submodule cv32e40p_wb_fifo: parameterised sync FIFO of wb_req_t with push/pop/full/empty/count and synchronous active-high reset.
- Port allocation and scoreboard stay in the top module.

Test Plan:
- **Bypass:** FIFO empty, apu_valid_i=1 addr=0x23 data=0xDEADBEEF, no ex/lsu → same cycle rf_we_a_o=1, addr=0x23, data=0xDEADBEEF; fifo_count_o stays 0.
- **Buffering with ports busy:** ex_we_i=1 (addr 5) and lsu_we_i=1 (addr 6) for 3 cycles while APU presents results to 0x21 then 0x22.
  - Both results are enqueued, count=2, apu_ready_o=0.
  - Cycle after ex/lsu go idle: 0x21 on port A, count=1.
  - Next cycle: 0x22 on port A, count=0.
- **Full-FIFO backpressure:** count=2, apu_valid_i held, lsu busy, ex idle → head drains on A, count=1, ready rises only the following cycle; no entry is lost or duplicated.
- **Scoreboard:** apu_issue_i to 0x2A → pending_o[42]=1 next cycle. When the result for 0x2A is granted, pending_o[42]=0 next cycle. Same-cycle issue and retire to 0x2A leaves the bit at 1.
- **Reset mid-op:** FIFO count=2 and pending bits set, assert rst for 1 cycle → count=0, pending_o=0, rf_we_*=0 during reset; a subsequent APU result bypasses normally.
- **Port B fallback:** ex_we_i=1, lsu idle, FIFO empty, APU valid → APU result on port B in the same cycle.
